// File: rtl/ext_result_stage.sv
// Result/retire stage behind the extended ALU.
// Pairs issue metadata with the one-cycle-late ALU result, buffers results, and maintains Z/N/V.
module ext_result_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [2:0]        iss_func,
  input  logic [REG_W-1:0]  iss_dst,
  input  logic              iss_we,
  input  logic              iss_setf,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ov,
  input  logic              flush,
  output logic              dm_valid,
  input  logic              dm_ready,
  output logic [DATA_W-1:0] dm_data,
  output logic [REG_W-1:0]  dm_dst,
  output logic              dm_we,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  input  logic [REG_W-1:0]  hz_query,
  output logic              hz_hit
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [2:0] F_MUL  = 3'b000;
  localparam logic [2:0] F_UMUL = 3'b001;
  localparam logic [2:0] F_FTI  = 3'b110;

  typedef struct packed {
    logic [2:0]       func;
    logic [REG_W-1:0] dst;
    logic             we;
    logic             setf;
    logic             ov;
  } meta_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    meta_t             meta;
  } entry_t;

  logic             p1_valid_q, p1_valid_d;
  meta_t            p1_q, p1_d;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       flags_q, flags_d;
  entry_t           head;
  logic             fire, push, pop;
  logic             z_c, n_c;

  // Ready depends only on registered state so a landing result always has a slot.
  assign iss_ready = (SUM_W'(count_q) + SUM_W'(p1_valid_q)) < SUM_W'(DEPTH);
  assign fire      = iss_valid & iss_ready & ~flush;
  assign push      = p1_valid_q;
  assign dm_valid  = (count_q != '0);
  assign pop       = dm_valid & dm_ready;
  assign head      = fifo_q[rd_ptr_q];

  assign dm_data = dm_valid ? head.data : '0;
  assign dm_dst  = dm_valid ? head.meta.dst : '0;
  assign dm_we   = dm_valid & head.meta.we;
  assign {flag_z, flag_n, flag_v} = flags_q;

  // Integer-typed results test the full word for zero; float-typed ones ignore the sign bit.
  always_comb begin
    if (head.meta.func inside {F_MUL, F_UMUL, F_FTI}) z_c = (head.data == '0);
    else                                              z_c = (head.data[DATA_W-2:0] == '0);
    n_c = (head.meta.func != F_UMUL) & head.data[DATA_W-1];
  end

  always_comb begin
    p1_valid_d = fire;
    p1_d       = p1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    if (fire) p1_d = '{func: iss_func, dst: iss_dst, we: iss_we, setf: iss_setf, ov: alu_ov};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (pop && head.meta.setf) flags_d = {z_c, n_c, head.meta.ov};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_q <= 1'b0;
      p1_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flags_q    <= '0;
    end else begin
      p1_valid_q <= p1_valid_d;
      p1_q       <= p1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) fifo_q[wr_ptr_q] <= {alu_result, p1_q};
  end

  // Pending-write lookup over the P1 slot and every occupied FIFO entry.
  always_comb begin
    logic [PTR_W-1:0] off;
    off    = '0;
    hz_hit = p1_valid_q & p1_q.we & (p1_q.dst == hz_query);
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(off) < count_q) && fifo_q[i].meta.we && (fifo_q[i].meta.dst == hz_query))
        hz_hit = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == CNT_W'(DEPTH))));
      assert (!(pop && (count_q == '0)));
    end
  end

endmodule

// File: tb/tb_ext_result_stage.sv
// Directed bench for ext_result_stage with hand-computed expected values.
module tb_ext_result_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [2:0] F_MUL  = 3'b000;
  localparam logic [2:0] F_UMUL = 3'b001;
  localparam logic [2:0] F_ADDF = 3'b010;
  localparam logic [2:0] F_FTI  = 3'b110;
  localparam logic [2:0] F_UND  = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid, iss_ready;
  logic [2:0]        iss_func;
  logic [REG_W-1:0]  iss_dst;
  logic              iss_we, iss_setf;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ov, flush;
  logic              dm_valid, dm_ready;
  logic [DATA_W-1:0] dm_data;
  logic [REG_W-1:0]  dm_dst;
  logic              dm_we;
  logic              flag_z, flag_n, flag_v;
  logic [REG_W-1:0]  hz_query;
  logic              hz_hit;

  int n_vec = 0;
  int n_err = 0;

  ext_result_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_dst(iss_dst), .iss_we(iss_we), .iss_setf(iss_setf),
    .alu_result(alu_result), .alu_ov(alu_ov), .flush(flush),
    .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_data(dm_data),
    .dm_dst(dm_dst), .dm_we(dm_we),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .hz_query(hz_query), .hz_hit(hz_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({flag_z, flag_n, flag_v});
  endfunction

  task automatic set_op(input logic [2:0] f, input int d, input logic we, input logic setf,
                        input logic ov);
    iss_func = f; iss_dst = REG_W'(d); iss_we = we; iss_setf = setf; alu_ov = ov;
    iss_valid = 1'b1;
  endtask

  // Issue one op, then present its ALU result; afterwards it sits at the FIFO head.
  task automatic run_op(input logic [2:0] f, input int d, input logic we, input logic setf,
                        input logic ov, input logic [31:0] res);
    set_op(f, d, we, setf, ov);
    tick();
    iss_valid = 1'b0; alu_ov = 1'b0; alu_result = res;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dm_valid"}, 32'(dm_valid), 32'd0);
    check_eq({tag, "_dm_data"}, dm_data, 32'd0);
    check_eq({tag, "_dm_dst"}, 32'(dm_dst), 32'd0);
    check_eq({tag, "_dm_we"}, 32'(dm_we), 32'd0);
    check_eq({tag, "_hz_hit"}, 32'(hz_hit), 32'd0);
    check_eq({tag, "_iss_ready"}, 32'(iss_ready), 32'd1);
    check_eq({tag, "_flags"}, flags(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sp_data [6];
    int sent, rcv, prev_idx, nxt_idx;
    logic prev_fire, nxt_fire;

    rst = 1'b1; iss_valid = 1'b0; iss_func = '0; iss_dst = '0; iss_we = 1'b0;
    iss_setf = 1'b0; alu_result = '0; alu_ov = 1'b0; flush = 1'b0; dm_ready = 1'b0;
    hz_query = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("rst");

    // Single ADDF, two-cycle latency to dm_valid
    dm_ready = 1'b1;
    set_op(F_ADDF, 3, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("addf_lat1_valid", 32'(dm_valid), 32'd0);
    iss_valid = 1'b0; alu_result = 32'h4040_0000;
    tick();
    check_eq("addf_valid", 32'(dm_valid), 32'd1);
    check_eq("addf_data", dm_data, 32'h4040_0000);
    check_eq("addf_dst", 32'(dm_dst), 32'd3);
    check_eq("addf_we", 32'(dm_we), 32'd1);
    tick();
    check_eq("addf_popped", 32'(dm_valid), 32'd0);
    check_eq("addf_flags", flags(), 32'b000);

    // Back-pressure: third issue refused while two are outstanding
    dm_ready = 1'b0;
    set_op(F_MUL, 10, 1'b1, 1'b0, 1'b0);
    check_eq("bp_ready0", 32'(iss_ready), 32'd1);
    tick();
    set_op(F_MUL, 11, 1'b1, 1'b0, 1'b0); alu_result = 32'hAAAA_0001;
    check_eq("bp_ready1", 32'(iss_ready), 32'd1);
    tick();
    set_op(F_MUL, 12, 1'b1, 1'b0, 1'b0); alu_result = 32'hAAAA_0002;
    check_eq("bp_ready2", 32'(iss_ready), 32'd0);
    tick();
    check_eq("bp_ready3", 32'(iss_ready), 32'd0);
    iss_valid = 1'b0; dm_ready = 1'b1;
    check_eq("bp_head0", dm_data, 32'hAAAA_0001);
    check_eq("bp_dst0", 32'(dm_dst), 32'd10);
    tick();
    check_eq("bp_ready_back", 32'(iss_ready), 32'd1);
    check_eq("bp_head1", dm_data, 32'hAAAA_0002);
    check_eq("bp_dst1", 32'(dm_dst), 32'd11);
    tick();
    check_eq("bp_drained", 32'(dm_valid), 32'd0);

    // Hazard tracking through P1 and FIFO residence
    dm_ready = 1'b0; hz_query = REG_W'(7);
    set_op(F_MUL, 7, 1'b1, 1'b0, 1'b0);
    check_eq("hz_before", 32'(hz_hit), 32'd0);
    tick();
    iss_valid = 1'b0;
    check_eq("hz_p1", 32'(hz_hit), 32'd1);
    tick();
    check_eq("hz_fifo", 32'(hz_hit), 32'd1);
    tick();
    check_eq("hz_fifo_hold", 32'(hz_hit), 32'd1);
    dm_ready = 1'b1;
    tick();
    check_eq("hz_after_pop", 32'(hz_hit), 32'd0);
    set_op(F_MUL, 7, 1'b0, 1'b0, 1'b0);
    tick();
    iss_valid = 1'b0;
    check_eq("hz_nowe_p1", 32'(hz_hit), 32'd0);
    tick();
    check_eq("hz_nowe_fifo", 32'(hz_hit), 32'd0);
    tick();

    // Flag rules on retire
    run_op(F_ADDF, 4, 1'b1, 1'b1, 1'b1, 32'h8000_0000); tick();
    check_eq("flg_addf_neg0", flags(), 32'b111);
    run_op(F_MUL, 5, 1'b1, 1'b0, 1'b0, 32'h0); tick();
    check_eq("flg_mul_nosetf", flags(), 32'b111);
    run_op(F_UMUL, 6, 1'b1, 1'b1, 1'b0, 32'h8000_0000); tick();
    check_eq("flg_umul", flags(), 32'b000);
    run_op(F_MUL, 8, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    check_eq("flg_mul_zero", flags(), 32'b100);
    run_op(F_UND, 9, 1'b1, 1'b1, 1'b0, 32'h8000_0000);
    check_eq("und_data", dm_data, 32'h8000_0000);
    tick();
    check_eq("flg_undef", flags(), 32'b110);
    run_op(F_FTI, 2, 1'b1, 1'b1, 1'b1, 32'h8000_0000); tick();
    check_eq("flg_fti", flags(), 32'b011);

    // Streaming with simultaneous push/pop; order must survive pointer wrap
    for (int k = 0; k < 6; k++) sp_data[k] = 32'(k + 1) * 32'h0101_0101;
    sent = 0; rcv = 0; prev_fire = 1'b0; prev_idx = 0; dm_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      alu_result = prev_fire ? sp_data[prev_idx] : 32'h0;
      if (dm_valid) begin
        check_eq("pp_data", dm_data, sp_data[rcv]);
        rcv++;
      end
      nxt_fire = 1'b0; nxt_idx = 0;
      if (sent < 6 && iss_ready) begin
        set_op(F_MUL, sent + 16, 1'b1, 1'b0, 1'b0);
        nxt_fire = 1'b1; nxt_idx = sent; sent++;
      end else begin
        iss_valid = 1'b0;
      end
      prev_fire = nxt_fire; prev_idx = nxt_idx;
      tick();
    end
    iss_valid = 1'b0;
    check_eq("pp_count", 32'(rcv), 32'd6);

    // Flush with two buffered entries and an issue attempt
    dm_ready = 1'b0; hz_query = REG_W'(12);
    set_op(F_MUL, 12, 1'b1, 1'b1, 1'b0);
    tick();
    set_op(F_ADDF, 13, 1'b1, 1'b1, 1'b0); alu_result = 32'h0;
    tick();
    iss_valid = 1'b0; alu_result = 32'h3F80_0000;
    tick();
    check_eq("fl_pre_valid", 32'(dm_valid), 32'd1);
    check_eq("fl_pre_ready", 32'(iss_ready), 32'd0);
    check_eq("fl_pre_hz", 32'(hz_hit), 32'd1);
    flush = 1'b1; dm_ready = 1'b1;
    set_op(F_MUL, 12, 1'b1, 1'b1, 1'b0);
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check_eq("fl_valid", 32'(dm_valid), 32'd0);
    check_eq("fl_hz", 32'(hz_hit), 32'd0);
    check_eq("fl_ready", 32'(iss_ready), 32'd1);
    check_eq("fl_flags", flags(), 32'b011);

    // Flush discards an issue accepted in the same cycle
    dm_ready = 1'b0; hz_query = REG_W'(14);
    run_op(F_MUL, 13, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    flush = 1'b1;
    set_op(F_MUL, 14, 1'b1, 1'b1, 1'b0);
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check_eq("fl2_hz", 32'(hz_hit), 32'd0);
    tick();
    check_eq("fl2_no_push", 32'(dm_valid), 32'd0);

    // Reset mid-stream drops everything and clears flags
    hz_query = REG_W'(20);
    set_op(F_MUL, 20, 1'b1, 1'b1, 1'b0);
    tick();
    set_op(F_MUL, 20, 1'b1, 1'b1, 1'b0); alu_result = 32'h5555_5555;
    tick();
    iss_valid = 1'b0;
    check_eq("mid_hz", 32'(hz_hit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
